// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: load/store operation codes, FSM
// state encoding and small operation-class helpers.
package mem_stage_pkg;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [7:0] EXE_LB_OP  = 8'hE0;
  localparam logic [7:0] EXE_LH_OP  = 8'hE1;
  localparam logic [7:0] EXE_LW_OP  = 8'hE3;
  localparam logic [7:0] EXE_LBU_OP = 8'hE4;
  localparam logic [7:0] EXE_LHU_OP = 8'hE5;
  localparam logic [7:0] EXE_SB_OP  = 8'hE8;
  localparam logic [7:0] EXE_SH_OP  = 8'hE9;
  localparam logic [7:0] EXE_SW_OP  = 8'hEB;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mem_state_e;

  function automatic logic op_is_load(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic op_is_store(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational data alignment for the MEM stage: byte-lane enables, store
// replication and misalignment detection on the issue side; lane selection
// and sign/zero extension on the load-return side.
module mem_stage_align
  import mem_stage_pkg::*;
(
  input  logic [7:0]  st_aluop_i,
  input  logic [1:0]  st_addr_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_sel_o,
  output logic [31:0] st_wdata_o,
  output logic        misalign_o,
  input  logic [7:0]  ld_aluop_i,
  input  logic [1:0]  ld_addr_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Issue side: lane enables from access size and offset, data replicated to every lane
  always_comb begin
    st_sel_o   = 4'b0000;
    st_wdata_o = ZeroWord;
    misalign_o = 1'b0;
    case (st_aluop_i)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        st_sel_o   = 4'b0001 << st_addr_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
        misalign_o = st_addr_i[0];
        st_sel_o   = st_addr_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      EXE_LW_OP, EXE_SW_OP: begin
        misalign_o = |st_addr_i;
        st_sel_o   = 4'b1111;
        st_wdata_o = st_data_i;
      end
      default: ;
    endcase
  end

  assign ld_shift = ld_rdata_i >> {ld_addr_i, 3'b000};
  assign ld_byte  = ld_shift[7:0];
  assign ld_half  = ld_addr_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];

  // Return side: pick the addressed byte/half and extend to a full word
  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_aluop_i)
      EXE_LB_OP:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      EXE_LBU_OP: ld_data_o = {24'h000000, ld_byte};
      EXE_LH_OP:  ld_data_o = {{16{ld_half[15]}}, ld_half};
      EXE_LHU_OP: ld_data_o = {16'h0000, ld_half};
      default:    ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on the data bus with a req/ack
// handshake, stalls the pipeline while the access is outstanding and
// produces the aligned write-back value. Non-memory ops pass straight through.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_pc,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_pc,
  output logic [7:0]  mem_aluop,
  output logic        stallreq,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_dbe
);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d, we_q, we_d;
  logic [31:0]      addr_q, addr_d, bwdata_q, bwdata_d;
  logic [3:0]       sel_q, sel_d;
  logic [7:0]       aluop_q, aluop_d;
  logic [1:0]       off_q, off_d;
  logic [4:0]       wd_q, wd_d;
  logic             wreg_q, wreg_d, dbe_q, dbe_d;
  logic [31:0]      pc_q, pc_d, alu_q, alu_d, rdata_q, rdata_d;

  logic [3:0]  st_sel;
  logic [31:0] st_wdata, ld_data;
  logic        misalign, is_ld, is_st, timeout;

  assign is_ld   = op_is_load(ex_aluop);
  assign is_st   = op_is_store(ex_aluop);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  mem_stage_align u_align (
    .st_aluop_i (ex_aluop),
    .st_addr_i  (ex_mem_addr[1:0]),
    .st_data_i  (ex_reg2),
    .st_sel_o   (st_sel),
    .st_wdata_o (st_wdata),
    .misalign_o (misalign),
    .ld_aluop_i (aluop_q),
    .ld_addr_i  (off_q),
    .ld_rdata_i (rdata_q),
    .ld_data_o  (ld_data)
  );

  // Next-state, bus register updates and stage outputs for each FSM state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    bwdata_d = bwdata_q;
    aluop_d  = aluop_q;
    off_d    = off_q;
    wd_d     = wd_q;
    wreg_d   = wreg_q;
    pc_d     = pc_q;
    alu_d    = alu_q;
    rdata_d  = rdata_q;
    dbe_d    = dbe_q;
    mem_wd    = ex_wd;
    mem_wreg  = ex_wreg;
    mem_wdata = ex_wdata;
    mem_pc    = ex_pc;
    mem_aluop = ex_aluop;
    stallreq  = 1'b0;
    exc_adel  = 1'b0;
    exc_ades  = 1'b0;
    exc_dbe   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (flush) begin
          mem_wreg = 1'b0;
        end else if (is_ld || is_st) begin
          mem_wreg = 1'b0;
          if (misalign) begin
            exc_adel = is_ld;
            exc_ades = is_st;
          end else begin
            stallreq = 1'b1;
            state_d  = ST_BUS;
            cnt_d    = '0;
            req_d    = 1'b1;
            we_d     = is_st;
            addr_d   = {ex_mem_addr[31:2], 2'b00};
            sel_d    = st_sel;
            bwdata_d = st_wdata;
            aluop_d  = ex_aluop;
            off_d    = ex_mem_addr[1:0];
            wd_d     = ex_wd;
            wreg_d   = ex_wreg;
            pc_d     = ex_pc;
            alu_d    = ex_wdata;
            dbe_d    = 1'b0;
          end
        end
      end
      ST_BUS: begin
        stallreq = 1'b1;
        mem_wreg = 1'b0;
        cnt_d    = cnt_q + 1'b1;
        if (dbus_ack) begin
          rdata_d = dbus_rdata;
          req_d   = 1'b0;
          state_d = flush ? ST_IDLE : ST_DONE;
        end else if (timeout) begin
          req_d   = 1'b0;
          dbe_d   = 1'b1;
          state_d = flush ? ST_IDLE : ST_DONE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Flushed access: keep the request alive until the bus finishes it
        mem_wreg = 1'b0;
        cnt_d    = cnt_q + 1'b1;
        if (dbus_ack || timeout) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        mem_wd    = wd_q;
        mem_pc    = pc_q;
        mem_aluop = aluop_q;
        mem_wdata = op_is_load(aluop_q) ? ld_data : alu_q;
        mem_wreg  = wreg_q & op_is_load(aluop_q) & ~dbe_q & ~flush;
        exc_dbe   = dbe_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, bus and capture registers; all cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= ZeroWord;
      sel_q    <= 4'b0000;
      bwdata_q <= ZeroWord;
      aluop_q  <= 8'h00;
      off_q    <= 2'b00;
      wd_q     <= 5'd0;
      wreg_q   <= 1'b0;
      pc_q     <= ZeroWord;
      alu_q    <= ZeroWord;
      rdata_q  <= ZeroWord;
      dbe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      bwdata_q <= bwdata_d;
      aluop_q  <= aluop_d;
      off_q    <= off_d;
      wd_q     <= wd_d;
      wreg_q   <= wreg_d;
      pc_q     <= pc_d;
      alu_q    <= alu_d;
      rdata_q  <= rdata_d;
      dbe_q    <= dbe_d;
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_sel   = sel_q;
  assign dbus_wdata = bwdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage with a behavioural model of
// load extraction, store lane/replication and alignment rules.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TMO = 64;

  logic        clk, rst, flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_mem_addr, ex_reg2, ex_pc;
  logic [7:0]  ex_aluop;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_sel;
  logic [4:0]  mem_wd;
  logic        mem_wreg, stallreq, exc_adel, exc_ades, exc_dbe;
  logic [31:0] mem_wdata, mem_pc;
  logic [7:0]  mem_aluop;

  int n_cmp = 0;
  int n_err = 0;

  // observations from the last run_access
  int          o_stall, o_req;
  logic        o_stable, o_hung, o_exc, o_we, o_wreg, o_dbe, o_req_done;
  logic [31:0] o_addr, o_wdata, o_res;
  logic [3:0]  o_sel;

  mem_stage #(.TIMEOUT_CYCLES(TMO), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_mem_addr(ex_mem_addr),
    .ex_reg2(ex_reg2), .ex_aluop(ex_aluop), .ex_pc(ex_pc),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_sel(dbus_sel),
    .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_pc(mem_pc),
    .mem_aluop(mem_aluop), .stallreq(stallreq),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_dbe(exc_dbe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int unsigned op_size(input logic [7:0] op);
    if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    logic [31:0] w, v;
    w = rd >> (8 * (addr % 4));
    case (op)
      EXE_LB_OP:  begin v = w & 32'hFF;   if (v >= 32'h80)   v = v + 32'hFFFFFF00; end
      EXE_LBU_OP: v = w & 32'hFF;
      EXE_LH_OP:  begin v = w & 32'hFFFF; if (v >= 32'h8000) v = v + 32'hFFFF0000; end
      EXE_LHU_OP: v = w & 32'hFFFF;
      default:    v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_sel(input logic [7:0] op, input logic [31:0] addr);
    int unsigned s;
    s = op_size(op);
    if (s == 4) return 4'hF;
    return 4'(((1 << s) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] ref_swdata(input logic [7:0] op, input logic [31:0] d);
    case (op_size(op))
      1:       return (d & 32'hFF) * 32'h01010101;
      2:       return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [7:0] rand_load_op();
    case ($urandom_range(0, 4))
      0: return EXE_LB_OP;
      1: return EXE_LBU_OP;
      2: return EXE_LH_OP;
      3: return EXE_LHU_OP;
      default: return EXE_LW_OP;
    endcase
  endfunction

  function automatic logic [7:0] rand_store_op();
    case ($urandom_range(0, 2))
      0: return EXE_SB_OP;
      1: return EXE_SH_OP;
      default: return EXE_SW_OP;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    ex_aluop    = 8'h00;
    ex_wreg     = 1'b1;
    ex_wd       = 5'($urandom);
    ex_wdata    = $urandom;
    ex_mem_addr = $urandom;
    ex_reg2     = $urandom;
    ex_pc       = $urandom;
    flush       = 1'b0;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] d,
                        input logic wreg);
    ex_aluop    = op;
    ex_mem_addr = addr;
    ex_reg2     = d;
    ex_wreg     = wreg;
    ex_wd       = 5'($urandom);
    ex_wdata    = $urandom;
    ex_pc       = $urandom;
    flush       = 1'b0;
  endtask

  // Runs one access from IDLE; ack on the lat-th request cycle (lat=0: never ack).
  task automatic run_access(input int lat, input logic [31:0] rd);
    int k;
    o_stall = 0; o_req = 0; o_stable = 1'b1; o_hung = 1'b0; o_exc = 1'b0; k = 0;
    #1;
    for (int g = 0; g < 300 && stallreq === 1'b1; g++) begin
      o_stall++;
      if (exc_adel || exc_ades || exc_dbe) o_exc = 1'b1;
      if (dbus_req === 1'b1) begin
        k++;
        o_req++;
        if (k == 1) begin
          o_addr = dbus_addr; o_sel = dbus_sel; o_we = dbus_we; o_wdata = dbus_wdata;
        end else if (dbus_addr !== o_addr || dbus_sel !== o_sel || dbus_we !== o_we ||
                     dbus_wdata !== o_wdata) begin
          o_stable = 1'b0;
        end
        if (k == lat) begin dbus_ack = 1'b1; dbus_rdata = rd; end
        else begin dbus_ack = 1'b0; dbus_rdata = $urandom; end
      end
      @(posedge clk);
      #1;
      dbus_ack = 1'b0;
      #1;
    end
    if (stallreq === 1'b1) o_hung = 1'b1;
    o_res = mem_wdata; o_wreg = mem_wreg; o_dbe = exc_dbe; o_req_done = dbus_req;
    set_nop();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_nop();
    dbus_ack = 1'b0; dbus_rdata = 32'h0;
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if ({dbus_req, dbus_we} !== 2'b00) begin n_err++;
      $display("FAIL reset req/we: got %b want 00", {dbus_req, dbus_we}); end
    n_cmp++; if ({dbus_addr, dbus_sel, dbus_wdata} !== 68'h0) begin n_err++;
      $display("FAIL reset bus: got %h want 0", {dbus_addr, dbus_sel, dbus_wdata}); end
    n_cmp++; if ({stallreq, exc_adel, exc_ades, exc_dbe} !== 4'b0000) begin n_err++;
      $display("FAIL reset stall/exc: got %b want 0000", {stallreq, exc_adel, exc_ades, exc_dbe}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lw_example();
    set_op(EXE_LW_OP, 32'h100, 32'h0, 1'b1);
    run_access(3, 32'hDEADBEEF);
    n_cmp++; if (o_stall !== 4) begin n_err++;
      $display("FAIL lw_ex stall cycles: got %0d want 4", o_stall); end
    n_cmp++; if (o_res !== 32'hDEADBEEF) begin n_err++;
      $display("FAIL lw_ex data: got %h want deadbeef", o_res); end
    n_cmp++; if (o_wreg !== 1'b1) begin n_err++;
      $display("FAIL lw_ex wreg: got %b want 1", o_wreg); end
    n_cmp++; if ({o_addr, o_we, o_req_done} !== {32'h100, 1'b0, 1'b0}) begin n_err++;
      $display("FAIL lw_ex bus addr/we/req_after: got %h %b %b want 100 0 0", o_addr, o_we, o_req_done); end
  endtask

  task automatic test_load_examples();
    logic [7:0]  ops [3] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LHU_OP};
    logic [31:0] ads [3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] exps[3] = '{32'hFFFFFF80, 32'h00000080, 32'h00008000};
    for (int i = 0; i < 3; i++) begin
      set_op(ops[i], ads[i], 32'h0, 1'b1);
      run_access(1, 32'h80000000);
      n_cmp++; if (o_res !== exps[i]) begin n_err++;
        $display("FAIL load_ex[%0d] data: got %h want %h", i, o_res, exps[i]); end
    end
  endtask

  task automatic test_loads_random();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] op; logic [31:0] addr, rd; int lat; logic wr;
      op = rand_load_op();
      addr = $urandom & ~(op_size(op) - 1);
      rd = $urandom; lat = $urandom_range(1, 4); wr = 1'($urandom);
      set_op(op, addr, $urandom, wr);
      run_access(lat, rd);
      n_cmp++; if (o_res !== ref_load(op, addr, rd)) begin n_err++;
        $display("FAIL ld_rand data op=%h a=%h: got %h want %h", op, addr, o_res, ref_load(op, addr, rd)); end
      n_cmp++; if (o_wreg !== wr) begin n_err++;
        $display("FAIL ld_rand wreg: got %b want %b", o_wreg, wr); end
      n_cmp++; if ({o_addr, o_we, o_stable} !== {addr & 32'hFFFFFFFC, 1'b0, 1'b1}) begin n_err++;
        $display("FAIL ld_rand bus addr/we/stable: got %h %b %b want %h 0 1", o_addr, o_we, o_stable, addr & 32'hFFFFFFFC); end
      n_cmp++; if (o_stall !== lat + 1) begin n_err++;
        $display("FAIL ld_rand stall cycles: got %0d want %0d", o_stall, lat + 1); end
    end
  endtask

  task automatic test_store_example();
    set_op(EXE_SB_OP, 32'h201, 32'h000000AB, 1'b1);
    run_access(2, 32'h0);
    n_cmp++; if ({o_sel, o_we} !== {4'b0010, 1'b1}) begin n_err++;
      $display("FAIL sb_ex sel/we: got %b %b want 0010 1", o_sel, o_we); end
    n_cmp++; if (o_wdata !== 32'hABABABAB) begin n_err++;
      $display("FAIL sb_ex wdata: got %h want abababab", o_wdata); end
    n_cmp++; if (o_wreg !== 1'b0) begin n_err++;
      $display("FAIL sb_ex wreg: got %b want 0", o_wreg); end
  endtask

  task automatic test_stores_random();
    for (int i = 0; i < 30; i++) begin
      logic [7:0] op; logic [31:0] addr, d;
      op = rand_store_op();
      addr = $urandom & ~(op_size(op) - 1);
      d = $urandom;
      set_op(op, addr, d, 1'b1);
      run_access($urandom_range(1, 3), $urandom);
      n_cmp++; if ({o_sel, o_we, o_stable} !== {ref_sel(op, addr), 1'b1, 1'b1}) begin n_err++;
        $display("FAIL st_rand sel/we/stable op=%h a=%h: got %b %b %b want %b 1 1", op, addr, o_sel, o_we, o_stable, ref_sel(op, addr)); end
      n_cmp++; if (o_wdata !== ref_swdata(op, d)) begin n_err++;
        $display("FAIL st_rand wdata: got %h want %h", o_wdata, ref_swdata(op, d)); end
      n_cmp++; if ({o_addr, o_wreg} !== {addr & 32'hFFFFFFFC, 1'b0}) begin n_err++;
        $display("FAIL st_rand addr/wreg: got %h %b want %h 0", o_addr, o_wreg, addr & 32'hFFFFFFFC); end
    end
  endtask

  task automatic test_misaligned();
    for (int i = 0; i < 12; i++) begin
      logic [7:0] op; logic [31:0] addr; logic ld;
      if (i == 0) begin op = EXE_LW_OP; addr = 32'h102; end
      else if (i == 1) begin op = EXE_SH_OP; addr = 32'h101; end
      else begin
        op = (i % 2 == 0) ? rand_load_op() : rand_store_op();
        if (op_size(op) == 1) op = (i % 2 == 0) ? EXE_LW_OP : EXE_SW_OP;
        addr = ($urandom & ~32'h3) | ((op_size(op) == 2) ? 32'h1 : 32'($urandom_range(1, 3)));
      end
      ld = (op_size(op) == 4) ? (op == EXE_LW_OP) : (op == EXE_LH_OP || op == EXE_LHU_OP);
      set_op(op, addr, $urandom, 1'b1);
      #1;
      n_cmp++; if ({exc_adel, exc_ades} !== {ld, ~ld}) begin n_err++;
        $display("FAIL misalign exc op=%h a=%h: got %b%b want %b%b", op, addr, exc_adel, exc_ades, ld, ~ld); end
      n_cmp++; if ({stallreq, mem_wreg} !== 2'b00) begin n_err++;
        $display("FAIL misalign stall/wreg: got %b%b want 00", stallreq, mem_wreg); end
      tick();
      n_cmp++; if (dbus_req !== 1'b0) begin n_err++;
        $display("FAIL misalign req: got %b want 0", dbus_req); end
      set_nop();
      tick();
    end
  endtask

  task automatic test_timeout();
    set_op(EXE_LW_OP, 32'h300, 32'h0, 1'b1);
    run_access(0, 32'h0);
    n_cmp++; if ({o_hung, o_req} !== {1'b0, TMO}) begin n_err++;
      $display("FAIL timeout req cycles: got hung=%b req=%0d want 0 %0d", o_hung, o_req, TMO); end
    n_cmp++; if ({o_dbe, o_wreg, o_req_done} !== 3'b100) begin n_err++;
      $display("FAIL timeout dbe/wreg/req: got %b%b%b want 100", o_dbe, o_wreg, o_req_done); end
    #1;
    n_cmp++; if ({exc_dbe, dbus_req} !== 2'b00) begin n_err++;
      $display("FAIL timeout dbe pulse: got %b%b want 00", exc_dbe, dbus_req); end
  endtask

  task automatic test_flush();
    // flush while the op sits in IDLE: no request, no write
    set_op(EXE_LW_OP, 32'h404, 32'h0, 1'b1);
    flush = 1'b1;
    #1;
    n_cmp++; if ({stallreq, mem_wreg} !== 2'b00) begin n_err++;
      $display("FAIL flush_idle stall/wreg: got %b%b want 00", stallreq, mem_wreg); end
    tick();
    n_cmp++; if (dbus_req !== 1'b0) begin n_err++;
      $display("FAIL flush_idle req: got %b want 0", dbus_req); end
    // flush during BUS: request held until ack, no result
    set_op(EXE_LW_OP, 32'h400, 32'h0, 1'b1);
    tick();
    flush = 1'b1;
    tick();
    set_nop();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if ({dbus_req, stallreq, mem_wreg, exc_adel, exc_ades, exc_dbe} !== 6'b100000) begin n_err++;
        $display("FAIL flush_drain[%0d] req/stall/wreg/exc: got %b want 100000", c,
                 {dbus_req, stallreq, mem_wreg, exc_adel, exc_ades, exc_dbe}); end
      tick();
    end
    dbus_ack = 1'b1; dbus_rdata = 32'h12345678;
    tick();
    dbus_ack = 1'b0;
    #1;
    n_cmp++; if (dbus_req !== 1'b0) begin n_err++;
      $display("FAIL flush_drain req after ack: got %b want 0", dbus_req); end
    n_cmp++; if ({mem_wdata, mem_wreg, exc_dbe} !== {ex_wdata, ex_wreg, 1'b0}) begin n_err++;
      $display("FAIL flush_drain no result: got %h %b %b want %h %b 0", mem_wdata, mem_wreg, exc_dbe, ex_wdata, ex_wreg); end
    tick();
  endtask

  task automatic test_rst_mid_bus();
    set_op(EXE_SW_OP, 32'h500, 32'hCAFEF00D, 1'b1);
    tick();
    n_cmp++; if (dbus_req !== 1'b1) begin n_err++;
      $display("FAIL rst_bus req before: got %b want 1", dbus_req); end
    set_nop();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if ({dbus_req, dbus_we} !== 2'b00) begin n_err++;
      $display("FAIL rst_bus req/we after: got %b%b want 00", dbus_req, dbus_we); end
    tick();
    n_cmp++; if ({stallreq, dbus_req} !== 2'b00) begin n_err++;
      $display("FAIL rst_bus idle: got %b%b want 00", stallreq, dbus_req); end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 20; i++) begin
      set_nop();
      ex_aluop = 8'($urandom_range(0, 8'hDF));
      ex_wreg = 1'($urandom);
      dbus_ack = 1'($urandom);
      dbus_rdata = $urandom;
      #1;
      n_cmp++; if ({mem_wd, mem_wreg, mem_wdata, mem_pc, mem_aluop, stallreq} !==
                   {ex_wd, ex_wreg, ex_wdata, ex_pc, ex_aluop, 1'b0}) begin n_err++;
        $display("FAIL passthru[%0d]: got %h want %h", i,
                 {mem_wd, mem_wreg, mem_wdata, mem_pc, mem_aluop, stallreq},
                 {ex_wd, ex_wreg, ex_wdata, ex_pc, ex_aluop, 1'b0}); end
      tick();
      n_cmp++; if ({dbus_req, exc_dbe} !== 2'b00) begin n_err++;
        $display("FAIL passthru stray ack[%0d]: got %b%b want 00", i, dbus_req, exc_dbe); end
    end
    dbus_ack = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_lw_example();
    test_load_examples();
    test_loads_random();
    test_store_example();
    test_stores_random();
    test_misaligned();
    test_timeout();
    test_flush();
    test_rst_mid_bus();
    test_passthrough();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
